// File: rtl/hidden_layer_mac.sv
// Multi-neuron hidden-layer MAC engine: streams one frame of samples,
// accumulates per-neuron weighted sums, then bias, shift, ReLU, saturate.
module hidden_layer_mac #(
  parameter int IN_W      = 8,
  parameter int W_W       = 10,
  parameter int N_NEURONS = 4,
  parameter int N_INPUTS  = 16,
  parameter int ACC_W     = 24,
  parameter int OUT_SHIFT = 4,
  parameter int OUT_W     = 16
) (
  input  logic                       Clock,
  input  logic                       Clear,
  input  logic                       start,
  input  logic                       relu_en,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [IN_W-1:0]            in_data,
  input  logic [N_NEURONS*W_W-1:0]   weight,
  input  logic [N_NEURONS*ACC_W-1:0] bias,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [N_NEURONS*OUT_W-1:0] out_data,
  output logic                       busy,
  output logic                       sat_flag
);

  localparam int PW = IN_W + W_W + 1;
  localparam int AW = (ACC_W > PW) ? ACC_W : PW;
  localparam int SW = AW + 1;
  localparam int XW = (ACC_W > OUT_W) ? ACC_W : OUT_W;
  localparam int CW = $clog2(N_INPUTS + 1);

  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic [OUT_W-1:0] OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCUM,
    S_BIAS,
    S_ACT,
    S_DONE
  } state_t;

  state_t                      r_state;
  logic signed [ACC_W-1:0]     r_acc [N_NEURONS];
  logic [CW-1:0]               r_cnt;
  logic                        r_relu;
  logic                        r_sat;
  logic                        r_out_valid;
  logic [N_NEURONS*OUT_W-1:0]  r_out;

  logic signed [ACC_W-1:0]     w_acc_nxt [N_NEURONS];
  logic [N_NEURONS-1:0]        w_acc_ovf;
  logic [OUT_W-1:0]            w_out_nxt [N_NEURONS];
  logic [N_NEURONS-1:0]        w_out_ovf;
  logic                        w_last;

  assign in_ready  = (r_state == S_ACCUM);
  assign busy      = (r_state != S_IDLE);
  assign out_valid = r_out_valid;
  assign out_data  = r_out;
  assign sat_flag  = r_sat;
  assign w_last    = (r_cnt == CW'(N_INPUTS - 1));

  for (genvar k = 0; k < N_NEURONS; k++) begin : g_neuron
    logic signed [PW-1:0]    w_a;
    logic signed [PW-1:0]    w_b;
    logic signed [PW-1:0]    w_prod;
    logic signed [AW-1:0]    w_add;
    logic signed [SW-1:0]    w_sum;
    logic [SW-ACC_W:0]       w_shi;
    logic signed [ACC_W-1:0] w_v;
    logic signed [ACC_W-1:0] w_r;
    logic signed [XW-1:0]    w_x;
    logic [XW-OUT_W:0]       w_xhi;

    assign w_a    = $signed({{(W_W+1){1'b0}}, in_data});
    assign w_b    = PW'($signed(weight[k*W_W +: W_W]));
    assign w_prod = w_a * w_b;

    // The same adder serves sample products in ACCUM and the bias in BIAS
    assign w_add = (r_state == S_BIAS)
                 ? AW'($signed(bias[k*ACC_W +: ACC_W]))
                 : AW'(w_prod);
    assign w_sum = SW'(r_acc[k]) + SW'(w_add);
    assign w_shi = w_sum[SW-1:ACC_W-1];

    assign w_acc_ovf[k] = !((&w_shi) || !(|w_shi));
    assign w_acc_nxt[k] = w_acc_ovf[k]
                        ? (w_sum[SW-1] ? ACC_MIN : ACC_MAX)
                        : w_sum[ACC_W-1:0];

    assign w_v   = r_acc[k] >>> OUT_SHIFT;
    assign w_r   = (r_relu && w_v[ACC_W-1]) ? '0 : w_v;
    assign w_x   = XW'(w_r);
    assign w_xhi = w_x[XW-1:OUT_W-1];

    assign w_out_ovf[k] = !((&w_xhi) || !(|w_xhi));
    assign w_out_nxt[k] = w_out_ovf[k]
                        ? (w_x[XW-1] ? OUT_MIN : OUT_MAX)
                        : w_x[OUT_W-1:0];
  end

  always_ff @(posedge Clock) begin
    if (Clear) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_relu      <= 1'b0;
      r_sat       <= 1'b0;
      r_out_valid <= 1'b0;
      r_out       <= '0;
      for (int k = 0; k < N_NEURONS; k++) r_acc[k] <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_ACCUM;
            r_cnt   <= '0;
            r_sat   <= 1'b0;
            r_relu  <= relu_en;
            for (int k = 0; k < N_NEURONS; k++) r_acc[k] <= '0;
          end
        end
        S_ACCUM: begin
          if (in_valid) begin
            for (int k = 0; k < N_NEURONS; k++) r_acc[k] <= w_acc_nxt[k];
            if (|w_acc_ovf) r_sat <= 1'b1;
            r_cnt <= r_cnt + CW'(1);
            if (w_last) r_state <= S_BIAS;
          end
        end
        S_BIAS: begin
          for (int k = 0; k < N_NEURONS; k++) r_acc[k] <= w_acc_nxt[k];
          if (|w_acc_ovf) r_sat <= 1'b1;
          r_state <= S_ACT;
        end
        S_ACT: begin
          for (int k = 0; k < N_NEURONS; k++)
            r_out[k*OUT_W +: OUT_W] <= w_out_nxt[k];
          if (|w_out_ovf) r_sat <= 1'b1;
          r_out_valid <= 1'b1;
          r_state     <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hidden_layer_mac.sv
// Directed bench for hidden_layer_mac: table of frames plus
// backpressure, stall, 16-bit accumulator and abort sequences.
module tb_hidden_layer_mac;

  logic        clk;
  logic        Clear;
  logic        start, start16;
  logic        relu_en;
  logic        in_valid;
  logic        in_ready, in_ready16;
  logic [7:0]  in_data;
  logic [39:0] weight;
  logic [95:0] bias;
  logic [63:0] bias16;
  logic        out_valid, out_valid16;
  logic        out_ready;
  logic [63:0] out_data, out_data16;
  logic        busy, busy16;
  logic        sat_flag, sat16;

  int checks = 0;
  int failures = 0;

  hidden_layer_mac dut (
    .Clock(clk), .Clear(Clear), .start(start), .relu_en(relu_en),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .weight(weight), .bias(bias), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .busy(busy),
    .sat_flag(sat_flag)
  );

  hidden_layer_mac #(.ACC_W(16)) dut16 (
    .Clock(clk), .Clear(Clear), .start(start16), .relu_en(relu_en),
    .in_valid(in_valid), .in_ready(in_ready16), .in_data(in_data),
    .weight(weight), .bias(bias16), .out_valid(out_valid16),
    .out_ready(out_ready), .out_data(out_data16), .busy(busy16),
    .sat_flag(sat16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        relu;
    logic [7:0]  din;
    logic [39:0] w;
    logic [95:0] b;
    logic [63:0] e;
    logic        esat;
  } vec_t;

  vec_t tbl [6];

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic run_frame(input vec_t v, input int hold, input bit gaps,
                           input string tag);
    int n;
    int cyc;
    relu_en   = v.relu;
    in_data   = v.din;
    weight    = v.w;
    bias      = v.b;
    out_ready = (hold == 0);
    start = 1'b1;
    step;
    start = 1'b0;
    chk({tag, " busy_accum"}, busy, 1);
    chk({tag, " in_ready_accum"}, in_ready, 1);
    chk({tag, " sat_cleared"}, sat_flag, 0);
    n = 0;
    cyc = 0;
    while (n < 16 && cyc < 400) begin
      in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      if (in_valid && in_ready) n++;
      step;
      cyc++;
    end
    in_valid = 1'b0;
    chk({tag, " accepts"}, n, 16);
    chk({tag, " in_ready_bias"}, in_ready, 0);
    chk({tag, " ov_bias"}, out_valid, 0);
    step;
    chk({tag, " ov_act"}, out_valid, 0);
    step;
    chk({tag, " latency"}, out_valid, 1);
    for (int k = 0; k < 4; k++)
      chk($sformatf("%s neuron%0d", tag, k),
          out_data[k*16 +: 16], v.e[k*16 +: 16]);
    chk({tag, " sat"}, sat_flag, v.esat);
    for (int i = 0; i < hold; i++) begin
      out_ready = 1'b0;
      start = 1'b1;
      step;
      chk({tag, " hold_valid"}, out_valid, 1);
      chk({tag, " hold_busy"}, busy, 1);
      chk({tag, " hold_data"}, out_data, v.e);
    end
    out_ready = 1'b1;
    start = 1'b1;
    step;
    start = 1'b0;
    chk({tag, " ov_drop"}, out_valid, 0);
    chk({tag, " idle"}, busy, 0);
    step;
    chk({tag, " start_ignored"}, busy, 0);
    chk({tag, " data_kept"}, out_data, v.e);
  endtask

  initial begin
    int n;
    int cyc;
    tbl[0] = '{1'b0, 8'd10,
               {10'sd0, 10'sd2, -10'sd1, 10'sd1},
               96'd0,
               {16'sd0, 16'sd20, -16'sd10, 16'sd10}, 1'b0};
    tbl[1] = '{1'b1, 8'd10,
               {10'sd0, 10'sd2, -10'sd1, 10'sd1},
               {24'sd0, 24'sd0, 24'sd32, 24'sd0},
               {16'sd0, 16'sd20, 16'sd0, 16'sd10}, 1'b0};
    tbl[2] = '{1'b0, 8'd255,
               {10'sd1, 10'sd0, -10'sd512, 10'sd511},
               96'd0,
               {16'sd255, 16'sd0, -16'sd32768, 16'sd32767}, 1'b1};
    tbl[3] = '{1'b0, 8'd3,
               {-10'sd1, 10'sd100, -10'sd7, 10'sd5},
               {24'sd1000, -24'sd1, -24'sd16, 24'sd16},
               {16'sd59, 16'sd299, -16'sd22, 16'sd16}, 1'b0};
    tbl[4] = '{1'b0, 8'd1,
               {10'sd0, 10'sd0, 10'sd1, -10'sd1},
               {24'sd15, -24'sd16, -24'sd1, -24'sd1},
               {16'sd0, -16'sd1, 16'sd0, -16'sd2}, 1'b0};
    tbl[5] = '{1'b1, 8'd1,
               {10'sd0, 10'sd0, 10'sd1, -10'sd1},
               {24'sd15, -24'sd16, -24'sd1, -24'sd1},
               64'd0, 1'b0};

    Clear = 1'b1;
    start = 1'b0;
    start16 = 1'b0;
    relu_en = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    weight = '0;
    bias = '0;
    bias16 = '0;
    out_ready = 1'b1;
    step;
    step;
    Clear = 1'b0;
    chk("rst busy", busy, 0);
    chk("rst in_ready", in_ready, 0);
    chk("rst out_valid", out_valid, 0);
    chk("rst out_data", out_data, 0);
    chk("rst sat", sat_flag, 0);
    chk("rst16 busy", busy16, 0);

    in_valid = 1'b1;
    step;
    chk("idle no_accept", in_ready, 0);
    in_valid = 1'b0;

    for (int i = 0; i < 6; i++)
      run_frame(tbl[i], 0, 1'b0, $sformatf("vec%0d", i));

    run_frame(tbl[3], 5, 1'b0, "backpressure");
    run_frame(tbl[0], 0, 1'b1, "stalls");

    weight  = {10'sd0, 10'sd1, -10'sd512, 10'sd511};
    in_data = 8'd255;
    relu_en = 1'b0;
    out_ready = 1'b1;
    start16 = 1'b1;
    step;
    start16 = 1'b0;
    n = 0;
    cyc = 0;
    while (n < 16 && cyc < 400) begin
      in_valid = 1'b1;
      if (in_ready16) n++;
      step;
      cyc++;
    end
    in_valid = 1'b0;
    chk("acc16 accepts", n, 16);
    step;
    step;
    chk("acc16 valid", out_valid16, 1);
    chk("acc16 n0", out_data16[15:0], 16'd2047);
    chk("acc16 n1", out_data16[31:16], 16'hF800);
    chk("acc16 n2", out_data16[47:32], 16'd255);
    chk("acc16 n3", out_data16[63:48], 16'd0);
    chk("acc16 sat", sat16, 1);
    step;
    chk("acc16 sat_sticky", sat16, 1);
    start16 = 1'b1;
    step;
    start16 = 1'b0;
    chk("acc16 sat_clr", sat16, 0);

    relu_en = 1'b0;
    in_data = tbl[0].din;
    weight  = tbl[0].w;
    bias    = tbl[0].b;
    start = 1'b1;
    step;
    start = 1'b0;
    n = 0;
    cyc = 0;
    while (n < 7 && cyc < 100) begin
      in_valid = 1'b1;
      if (in_ready) n++;
      step;
      cyc++;
    end
    chk("abort accepts", n, 7);
    Clear = 1'b1;
    step;
    Clear = 1'b0;
    in_valid = 1'b0;
    chk("abort busy", busy, 0);
    chk("abort in_ready", in_ready, 0);
    chk("abort out_valid", out_valid, 0);
    chk("abort out_data", out_data, 0);
    chk("abort sat", sat_flag, 0);
    chk("abort busy16", busy16, 0);
    run_frame(tbl[0], 0, 1'b0, "after_abort");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
